// File: rtl/cordic_issue_ctrl.sv
// Request queue, mode-aware issue FSM, latency-tracking token pipe and result FIFO around the CORDIC core.
// Define CORDIC_RANGE_CHK_EN to flag rotate requests whose angle magnitude exceeds PI (res_err).
module cordic_issue_ctrl #(
  parameter int CORDIC_LAT = 10,
  parameter int REQ_DEPTH  = 4,
  parameter int RES_DEPTH  = 8,
  parameter int TAG_W      = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_mode,
  input  logic [15:0]      i_req_x,
  input  logic [15:0]      i_req_y,
  input  logic [15:0]      i_req_angle,
  input  logic [TAG_W-1:0] i_req_tag,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [15:0]      o_res_a,
  output logic [15:0]      o_res_b,
  output logic [TAG_W-1:0] o_res_tag,
  output logic             o_res_mode,
  output logic             o_res_err,
  output logic             o_op_mode,
  output logic [15:0]      o_x_coordinate,
  output logic [15:0]      o_y_coordinate,
  output logic [15:0]      o_rotate_amount,
  input  logic [15:0]      i_x_or_phase_out,
  input  logic [15:0]      i_y_or_size_out,
  output logic             o_busy
);

  localparam int RQ_AW = $clog2(REQ_DEPTH);
  localparam int RQ_CW = RQ_AW + 1;
  localparam int RS_AW = $clog2(RES_DEPTH);
  localparam int RS_CW = RS_AW + 1;
  localparam int IF_W  = $clog2(CORDIC_LAT + 1);
  localparam int CR_W  = $clog2(CORDIC_LAT + RES_DEPTH + 1);
  localparam int REQ_W = TAG_W + 49;
  localparam int TOK_W = TAG_W + 2;
  localparam int RES_W = TOK_W + 32;

  typedef enum logic {S_RUN, S_DRAIN} state_t;

  // ---------------- request FIFO ----------------
  logic [REQ_W-1:0] r_req_mem [REQ_DEPTH];
  logic [RQ_AW-1:0] r_req_wr, r_req_rd;
  logic [RQ_CW-1:0] r_req_cnt, w_req_cnt_next;
  logic             r_req_ready;
  logic             w_req_push, w_req_pop, w_req_empty;
  logic [REQ_W-1:0] w_head;
  logic             w_head_mode, w_head_err;
  logic [15:0]      w_head_x, w_head_y, w_head_ang;
  logic [TAG_W-1:0] w_head_tag;

  assign o_req_ready = r_req_ready;
  assign w_req_push  = i_req_valid & r_req_ready;
  assign w_req_empty = (r_req_cnt == '0);
  assign w_head      = r_req_mem[r_req_rd];
  assign w_head_tag  = w_head[TAG_W-1:0];
  assign w_head_ang  = w_head[TAG_W+15:TAG_W];
  assign w_head_y    = w_head[TAG_W+31:TAG_W+16];
  assign w_head_x    = w_head[TAG_W+47:TAG_W+32];
  assign w_head_mode = w_head[TAG_W+48];

`ifdef CORDIC_RANGE_CHK_EN
  assign w_head_err = !w_head_mode && (w_head_ang[14:0] > 15'h0324);
`else
  assign w_head_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (w_req_push) r_req_mem[r_req_wr] <= {i_req_mode, i_req_x, i_req_y, i_req_angle, i_req_tag};
  end

  always_comb begin
    w_req_cnt_next = r_req_cnt;
    if (w_req_push && !w_req_pop)      w_req_cnt_next = r_req_cnt + RQ_CW'(1);
    else if (!w_req_push && w_req_pop) w_req_cnt_next = r_req_cnt - RQ_CW'(1);
  end

  // Ready is registered so it is 0 throughout reset and rises on the first edge after release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_wr    <= '0;
      r_req_rd    <= '0;
      r_req_cnt   <= '0;
      r_req_ready <= 1'b0;
    end else begin
      if (w_req_push) r_req_wr <= r_req_wr + RQ_AW'(1);
      if (w_req_pop)  r_req_rd <= r_req_rd + RQ_AW'(1);
      r_req_cnt   <= w_req_cnt_next;
      r_req_ready <= (w_req_cnt_next != RQ_CW'(REQ_DEPTH));
    end
  end

  // ---------------- issue FSM ----------------
  state_t           r_state;
  logic             r_cur_mode;
  logic [IF_W-1:0]  r_inflight;
  logic [RS_CW-1:0] r_res_cnt;
  logic [CR_W-1:0]  w_credit;
  logic             w_issue, w_pipe_out;

  assign w_credit  = CR_W'(r_inflight) + CR_W'(r_res_cnt);
  assign w_issue   = (r_state == S_RUN) && !w_req_empty && (w_head_mode == r_cur_mode) &&
                     (w_credit < CR_W'(RES_DEPTH));
  assign w_req_pop = w_issue;

  // The core formats outputs from the live op_mode, so the mode only changes with an empty pipe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_RUN;
      r_cur_mode <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (!w_req_empty && (w_head_mode != r_cur_mode)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_inflight == '0) begin
            r_cur_mode <= w_head_mode;
            r_state    <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign o_op_mode       = r_cur_mode;
  assign o_x_coordinate  = w_issue ? w_head_x : 16'h0000;
  assign o_y_coordinate  = w_issue ? w_head_y : 16'h0000;
  assign o_rotate_amount = (w_issue && !w_head_mode) ? w_head_ang : 16'h0000;

  // ---------------- token pipe ----------------
  logic             w_stg_vld [CORDIC_LAT];
  logic [TOK_W-1:0] w_stg_tok [CORDIC_LAT];
  logic             r_pipe_vld [CORDIC_LAT];
  logic [TOK_W-1:0] r_pipe_tok [CORDIC_LAT];

  assign w_stg_vld[0] = w_issue;
  assign w_stg_tok[0] = {w_head_mode, w_head_err, w_head_tag};

  for (genvar gi = 1; gi < CORDIC_LAT; gi++) begin : g_link
    assign w_stg_vld[gi] = r_pipe_vld[gi-1];
    assign w_stg_tok[gi] = r_pipe_tok[gi-1];
  end

  for (genvar gi = 0; gi < CORDIC_LAT; gi++) begin : g_stage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_pipe_vld[gi] <= 1'b0;
        r_pipe_tok[gi] <= '0;
      end else begin
        r_pipe_vld[gi] <= w_stg_vld[gi];
        r_pipe_tok[gi] <= w_stg_tok[gi];
      end
    end
  end

  assign w_pipe_out = r_pipe_vld[CORDIC_LAT-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inflight <= '0;
    end else if (w_issue && !w_pipe_out) begin
      r_inflight <= r_inflight + IF_W'(1);
    end else if (!w_issue && w_pipe_out) begin
      r_inflight <= r_inflight - IF_W'(1);
    end
  end

  // ---------------- result FIFO ----------------
  logic [RES_W-1:0] r_res_mem [RES_DEPTH];
  logic [RS_AW-1:0] r_res_wr, r_res_rd;
  logic             w_res_pop;
  logic [RES_W-1:0] w_res_head;

  assign o_res_valid = (r_res_cnt != '0);
  assign w_res_pop   = o_res_valid & i_res_ready;
  assign w_res_head  = r_res_mem[r_res_rd];

  always_ff @(posedge i_clk) begin
    if (w_pipe_out) r_res_mem[r_res_wr] <= {i_x_or_phase_out, i_y_or_size_out, r_pipe_tok[CORDIC_LAT-1]};
  end

  // Credit gating at issue guarantees a free slot whenever a token leaves the pipe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res_wr  <= '0;
      r_res_rd  <= '0;
      r_res_cnt <= '0;
    end else begin
      if (w_pipe_out) r_res_wr <= r_res_wr + RS_AW'(1);
      if (w_res_pop)  r_res_rd <= r_res_rd + RS_AW'(1);
      if (w_pipe_out && !w_res_pop)      r_res_cnt <= r_res_cnt + RS_CW'(1);
      else if (!w_pipe_out && w_res_pop) r_res_cnt <= r_res_cnt - RS_CW'(1);
    end
  end

  assign o_res_a    = o_res_valid ? w_res_head[RES_W-1 -: 16] : 16'h0000;
  assign o_res_b    = o_res_valid ? w_res_head[RES_W-17 -: 16] : 16'h0000;
  assign o_res_mode = o_res_valid & w_res_head[TAG_W+1];
  assign o_res_err  = o_res_valid & w_res_head[TAG_W];
  assign o_res_tag  = o_res_valid ? w_res_head[TAG_W-1:0] : '0;

  assign o_busy = (r_req_cnt != '0) || (r_inflight != '0) || (r_res_cnt != '0);

endmodule
